// File: rtl/spad_port_ctrl.sv
// rtl/spad_port_ctrl.sv - single-port scratchpad access controller with read-response handshake
// Optional zero-fill engine enabled by defining SPAD_CLEAR_EN.
module spad_port_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  input  logic                  start_clear,
  output logic                  busy
);

`ifdef SPAD_CLEAR_EN
  typedef enum logic [1:0] {IDLE, RD_PEND, CLEAR} state_t;
`else
  typedef enum logic {IDLE, RD_PEND} state_t;
`endif

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   clr_addr;
  logic                    accept;
  logic                    clearing;
  logic                    clear_go;

`ifdef SPAD_CLEAR_EN
  logic [ADDR_WIDTH:0] clr_cnt;
  logic                clr_last;

  assign clearing = (state == CLEAR);
  assign clear_go = (state == IDLE) && start_clear;
  assign clr_addr = clr_cnt[ADDR_WIDTH-1:0];
  assign clr_last = (clr_cnt == {1'b0, {ADDR_WIDTH{1'b1}}});

  always_ff @(posedge clk) begin
    if (rst || clear_go) clr_cnt <= '0;
    else if (clearing)   clr_cnt <= clr_cnt + (ADDR_WIDTH+1)'(1);
  end
`else
  logic unused_start_clear;

  assign clearing           = 1'b0;
  assign clear_go           = 1'b0;
  assign clr_addr           = '0;
  assign unused_start_clear = start_clear;
`endif

  assign busy      = clearing;
  assign rsp_valid = (state == RD_PEND);
  assign rsp_rdata = ram_dout;
  // A clear request in IDLE takes priority over a same-cycle access.
  assign req_ready = !rst && !clearing && !clear_go && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;

  // ram_addr falls back to the held address so ram_dout stays stable while a response stalls.
  always_comb begin
    ram_cs   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = addr_q;
    ram_din  = req_wdata;
    if (accept) begin
      ram_cs   = 1'b1;
      ram_we   = req_we;
      ram_addr = req_addr;
    end else if (clearing && !rst) begin
      ram_cs   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = clr_addr;
      ram_din  = '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && !req_we) state_nxt = RD_PEND;
`ifdef SPAD_CLEAR_EN
        if (clear_go) state_nxt = CLEAR;
`endif
      end
      RD_PEND: begin
        if (rsp_ready) state_nxt = (accept && !req_we) ? RD_PEND : IDLE;
      end
`ifdef SPAD_CLEAR_EN
      CLEAR: begin
        if (clr_last) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      addr_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) addr_q <= req_addr;
    end
  end

endmodule

// File: tb/tb_spad_port_ctrl.sv
// tb/tb_spad_port_ctrl.sv - randomized scoreboard bench for spad_port_ctrl
module tb_spad_port_ctrl;
  localparam int AW    = 5;
  localparam int DW    = 128;
  localparam int DEPTH = 1 << AW;
`ifdef SPAD_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          ram_cs, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic          start_clear, busy;

  spad_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout),
    .start_clear(start_clear), .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM: registered address, combinational array read
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] mem_addr_q;
  always @(posedge clk) begin
    if (ram_cs && ram_we) mem[ram_addr] <= ram_din;
    if (ram_cs) mem_addr_q <= ram_addr;
  end
  assign ram_dout = mem[mem_addr_q];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: memory image, outstanding responses, clear progress
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [AW-1:0] last_addr = '0;
  bit            clr_active = 1'b0;
  int            clr_idx = 0;

  always @(negedge clk) begin
    bit pending, idle, rdy_exp;
    if (rst) begin
      chk1("rst_req_ready", req_ready, 1'b0);
      chk1("rst_ram_cs", ram_cs, 1'b0);
      chk1("rst_ram_we", ram_we, 1'b0);
      exp_q.delete();
      clr_active = 1'b0;
      clr_idx    = 0;
      last_addr  = '0;
    end else begin
      pending = (exp_q.size() != 0);
      idle    = !pending && !clr_active;
      rdy_exp = !clr_active && (!pending || rsp_ready) && !(CLEAR_EN && start_clear && idle);
      chk1("busy", busy, clr_active);
      chk1("rsp_valid", rsp_valid, pending);
      if (pending) chk("rsp_rdata", rsp_rdata, exp_q[0]);
      chk1("req_ready", req_ready, rdy_exp);
      if (clr_active) begin
        chk1("clr_cs", ram_cs, 1'b1);
        chk1("clr_we", ram_we, 1'b1);
        chk("clr_addr", DW'(ram_addr), DW'(clr_idx));
        chk("clr_din", ram_din, '0);
        ref_mem[clr_idx] = '0;
        clr_idx++;
        if (clr_idx == DEPTH) clr_active = 1'b0;
      end else if (req_valid && rdy_exp) begin
        chk1("acc_cs", ram_cs, 1'b1);
        chk1("acc_we", ram_we, req_we);
        chk("acc_addr", DW'(ram_addr), DW'(req_addr));
        if (req_we) chk("acc_din", ram_din, req_wdata);
      end else begin
        chk1("idle_cs", ram_cs, 1'b0);
        chk1("idle_we", ram_we, 1'b0);
        if (pending) chk("hold_addr", DW'(ram_addr), DW'(last_addr));
      end
      if (pending && rsp_ready) void'(exp_q.pop_front());
      if (!clr_active && req_valid && rdy_exp) begin
        if (req_we) ref_mem[req_addr] = req_wdata;
        else        exp_q.push_back(ref_mem[req_addr]);
        last_addr = req_addr;
      end
      if (CLEAR_EN && start_clear && idle) begin
        clr_active = 1'b1;
        clr_idx    = 0;
      end
    end
  end

  task automatic drive(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic rr, input logic sc);
    req_valid   = v;
    req_we      = we;
    req_addr    = a;
    req_wdata   = d;
    rsp_ready   = rr;
    start_clear = sc;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int n;
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
    rst = 1'b0;
    chk1("reset_rsp_valid", rsp_valid, 1'b0);
    chk1("reset_busy", busy, 1'b0);

    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b1, AW'(i), rnd_word(), 1'b1, 1'b0);

    drive(1'b1, 1'b1, AW'(3), {16{8'hA5}}, 1'b1, 1'b0);
    drive(1'b1, 1'b0, AW'(3), '0, 1'b1, 1'b0);
    chk1("a5_rsp_valid", rsp_valid, 1'b1);
    chk("a5_rsp_rdata", rsp_rdata, {16{8'hA5}});
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

    for (int i = 1; i <= 3; i++) drive(1'b1, 1'b0, AW'(i), '0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

    drive(1'b1, 1'b0, AW'(5), '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, AW'(9), rnd_word(), 1'b0, 1'b0);
    chk("stall_ram_addr", DW'(ram_addr), DW'(5));
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 3) != 0, 1'($urandom), AW'($urandom), rnd_word(),
            $urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0);
    for (int i = 0; i < 40; i++) drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

`ifdef SPAD_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b1, AW'(i), rnd_word(), 1'b1, 1'b0);
    drive(1'b1, 1'b1, AW'(7), rnd_word(), 1'b1, 1'b1);
    n = 0;
    while (busy && n < 100) begin
      n++;
      drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    end
    chk("clear_len", DW'(n), DW'(DEPTH));
    drive(1'b1, 1'b0, AW'(0), '0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, AW'(DEPTH-1), '0, 1'b1, 1'b0);
    chk("clear_rd_0", rsp_rdata, '0);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    chk("clear_rd_top", rsp_rdata, '0);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    rst = 1'b0;
    chk1("rst_clear_busy", busy, 1'b0);
    chk1("rst_clear_cs", ram_cs, 1'b0);
`else
    drive(1'b1, 1'b1, AW'(4), {16{8'h3C}}, 1'b1, 1'b1);
    chk1("noclr_busy", busy, 1'b0);
    drive(1'b1, 1'b0, AW'(4), '0, 1'b1, 1'b0);
    chk("noclr_rdata", rsp_rdata, {16{8'h3C}});
`endif
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

    drive(1'b1, 1'b0, AW'(2), '0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    chk1("rst_rd_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_rd_busy", busy, 1'b0);
    chk1("rst_rd_cs", ram_cs, 1'b0);

    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    chk("drain", DW'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
